div_int_pipe_hs: RTL

- Iterative integer divider for DATA_WIDTH-bit operands; signed or unsigned per operation.
- Retires STEPS_PER_CYCLE quotient bits per clock.
- valid/ready handshakes on input and output, synchronous flush, RISC-V-style special-case results and status flags.
- Sits behind the integer issue stage as a shared multi-cycle execution unit; supersedes the fixed-latency single-step divider.

---
 rtl/div_int_pipe_hs.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_int_pipe_hs.sv
// Iterative signed/unsigned divider, STEPS_PER_CYCLE quotient bits per clock; latency ITER+2 (special cases 1).
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module div_int_pipe_hs #(
    parameter int DATA_WIDTH      = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);
    localparam int W    = DATA_WIDTH;
    localparam int S    = STEPS_PER_CYCLE;
    localparam int ITER = W / S;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   dvs_q;
    logic           negq_q, negr_q;
    logic [W-1:0]   quot_q, rmdr_q;
    logic           dz_q, ov_q;

    logic           a_neg, b_neg, is_dz, is_ov, accept;
    logic [W-1:0]   a_mag, b_mag;

    // Operand decode: magnitudes for the unsigned core, signs for the FIX correction.
    always_comb begin
        a_neg  = opcode & dividend[W-1];
        b_neg  = opcode & divisor[W-1];
        a_mag  = a_neg ? -dividend : dividend;
        b_mag  = b_neg ? -divisor : divisor;
        is_dz  = (divisor == '0);
        is_ov  = opcode & (dividend == MIN_VAL) & (divisor == '1);
        accept = in_valid & (state_q == IDLE);
    end

    // Restoring steps chained within one cycle; sh holds unconsumed dividend bits above new quotient bits.
    always_comb begin
        logic [W:0] shifted;
        logic [W:0] trial;
        acc_d = acc_q;
        sh_d  = sh_q;
        for (int i = 0; i < S; i++) begin
            shifted = {acc_d, sh_d[W-1]};
            trial   = shifted - {1'b0, dvs_q};
            sh_d    = {sh_d[W-2:0], ~trial[W]};
            acc_d   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (is_dz | is_ov) ? DONE : CALC;
            CALC: if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rmdr_q;
        div_by_zero = dz_q;
        overflow    = ov_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            quot_q <= '0;
            rmdr_q <= '0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dz_q   <= is_dz;
                        ov_q   <= is_ov;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        sh_q   <= a_mag;
                        dvs_q  <= b_mag;
                        negq_q <= a_neg ^ b_neg;
                        negr_q <= a_neg;
                        if (is_dz) begin
                            quot_q <= '1;
                            rmdr_q <= dividend;
                        end else if (is_ov) begin
                            quot_q <= MIN_VAL;
                            rmdr_q <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= (cnt_q == CW'(ITER - 1)) ? '0 : cnt_q + 1'b1;
                end
                FIX: begin
                    quot_q <= negq_q ? -sh_q : sh_q;
                    rmdr_q <= negr_q ? -acc_q : acc_q;
                end
                default: ;
            endcase
        end
    end
endmodule
